usb_cmd_parser: RTL and testbench

USB_CMD_PARSER -- requirements
Module: usb_cmd_parser

---
 rtl/usb_cmd_pkg.sv | 28 ++
 rtl/usb_rx_byte_fetch.sv | 48 ++++
 rtl/usb_cmd_parser.sv | 173 +++++++++++++++++
 tb/tb_usb_cmd_parser.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_cmd_pkg
// Description : Shared definitions for the USB command parser: the frame FSM
//               state encoding, default SYNC/ACK/NAK byte values and the
//               frame length in bytes (SYNC, ADDR, D3..D0, CHK).
// Revision    : 1.0 - initial release
// ============================================================================
package usb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_ADDR = 3'd1,
        ST_D3   = 3'd2,
        ST_D2   = 3'd3,
        ST_D1   = 3'd4,
        ST_D0   = 3'd5,
        ST_CHK  = 3'd6,
        ST_RESP = 3'd7
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;
    localparam int         FRAME_LEN     = 7;

endpackage : usb_cmd_pkg
`default_nettype wire

// File: rtl/usb_rx_byte_fetch.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_byte_fetch
// Description : Issues single-cycle reads to a non-showahead RX FIFO and
//               flags the cycle in which the returned byte is valid.
//               A request is only issued when the FIFO holds data, the
//               previous read has returned and the parser allows fetching,
//               so at most one byte arrives every two cycles.
// Ports       : clk_i    - system clock
//               rst      - synchronous active-high reset
//               fetch_en - parser is able to accept a byte
//               rdusedw  - RX FIFO fill count
//               rdreq    - RX FIFO read request (registered)
//               byte_vld - FIFO read data is valid this cycle (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_byte_fetch (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       fetch_en,
    input  logic [8:0] rdusedw,
    output logic       rdreq,
    output logic       byte_vld
);

    // r_rdreq doubles as the in-flight flag: the FIFO answers exactly one
    // cycle after the request, so a read is outstanding only while it is high.
    logic r_rdreq;
    logic r_byte_vld;
    logic w_issue;

    assign w_issue = fetch_en && (rdusedw != 9'd0) && !r_rdreq;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_rdreq    <= 1'b0;
            r_byte_vld <= 1'b0;
        end else begin
            r_rdreq    <= w_issue;
            r_byte_vld <= r_rdreq;
        end
    end

    assign rdreq    = r_rdreq;
    assign byte_vld = r_byte_vld;

endmodule : usb_rx_byte_fetch
`default_nettype wire

// File: rtl/usb_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : usb_cmd_parser
// Description : Parses 7-byte command frames (SYNC, ADDR, D3..D0, CHK) from
//               an RX FIFO, issues a register write on a good XOR checksum
//               and answers with ACK, or NAK on bad checksum / inter-byte
//               timeout, through a TX FIFO. NAKed frames are counted.
// Ports       : clk_i         - system clock (RX read / TX write clock)
//               rst           - synchronous active-high reset
//               rxf_rdreq_o   - RX FIFO read request
//               rxf_rddata_i  - RX FIFO data, valid one cycle after request
//               rxf_rdusedw_i - RX FIFO fill count
//               txe_wrreq_o   - TX FIFO write request
//               txe_wrdata_o  - TX FIFO write data
//               txe_wrfull_i  - TX FIFO full flag
//               reg_wr_o      - one-cycle register write strobe
//               reg_addr_o    - register address
//               reg_wdata_o   - register write data
//               err_cnt_o     - saturating count of NAKed frames
// Revision    : 1.0 - initial release
// ============================================================================
module usb_cmd_parser
    import usb_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst,
    output logic        rxf_rdreq_o,
    input  logic [7:0]  rxf_rddata_i,
    input  logic [8:0]  rxf_rdusedw_i,
    output logic        txe_wrreq_o,
    output logic [7:0]  txe_wrdata_o,
    input  logic        txe_wrfull_i,
    output logic        reg_wr_o,
    output logic [7:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [15:0] err_cnt_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] c_TO_ONE  = TW'(1);

    frame_state_t r_state;
    frame_state_t w_state_next;

    logic          w_byte_vld;
    logic          w_fetch_en;
    logic          w_in_frame;
    logic          w_timeout;
    logic          w_chk_ok;
    logic          w_nak;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_chk;
    logic [7:0]    r_addr_buf;
    logic [31:0]   r_data_buf;
    logic [7:0]    r_resp;
    logic          r_txe_wrreq;
    logic [7:0]    r_txe_wrdata;
    logic          r_reg_wr;
    logic [7:0]    r_reg_addr;
    logic [31:0]   r_reg_wdata;
    logic [15:0]   r_err_cnt;

    // Fetching is gated on the next state so that no read can be launched
    // on the same edge the FSM enters RESP; such a byte would be lost.
    assign w_fetch_en = (w_state_next != ST_RESP);

    usb_rx_byte_fetch u_fetch (
        .clk_i    (clk_i),
        .rst      (rst),
        .fetch_en (w_fetch_en),
        .rdusedw  (rxf_rdusedw_i),
        .rdreq    (rxf_rdreq_o),
        .byte_vld (w_byte_vld)
    );

    assign w_in_frame = (r_state != ST_HUNT) && (r_state != ST_RESP);
    // A byte arriving in the last timeout cycle still counts as in time.
    assign w_timeout  = w_in_frame && !w_byte_vld && (r_to_cnt == c_TO_LAST);
    assign w_chk_ok   = (r_chk == rxf_rddata_i);
    assign w_nak      = w_timeout || ((r_state == ST_CHK) && w_byte_vld && !w_chk_ok);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT: if (w_byte_vld && (rxf_rddata_i == SYNC_BYTE)) w_state_next = ST_ADDR;
            ST_ADDR: if (w_byte_vld) w_state_next = ST_D3;   else if (w_timeout) w_state_next = ST_RESP;
            ST_D3:   if (w_byte_vld) w_state_next = ST_D2;   else if (w_timeout) w_state_next = ST_RESP;
            ST_D2:   if (w_byte_vld) w_state_next = ST_D1;   else if (w_timeout) w_state_next = ST_RESP;
            ST_D1:   if (w_byte_vld) w_state_next = ST_D0;   else if (w_timeout) w_state_next = ST_RESP;
            ST_D0:   if (w_byte_vld) w_state_next = ST_CHK;  else if (w_timeout) w_state_next = ST_RESP;
            ST_CHK:  if (w_byte_vld || w_timeout) w_state_next = ST_RESP;
            ST_RESP: if (!txe_wrfull_i) w_state_next = ST_HUNT;
            default: w_state_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_to_cnt     <= '0;
            r_chk        <= 8'h00;
            r_addr_buf   <= 8'h00;
            r_data_buf   <= 32'h0;
            r_resp       <= 8'h00;
            r_txe_wrreq  <= 1'b0;
            r_txe_wrdata <= 8'h00;
            r_reg_wr     <= 1'b0;
            r_reg_addr   <= 8'h00;
            r_reg_wdata  <= 32'h0;
            r_err_cnt    <= 16'h0;
        end else begin
            r_state     <= w_state_next;
            r_reg_wr    <= 1'b0;
            r_txe_wrreq <= 1'b0;

            if (!w_in_frame || w_byte_vld || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_ONE;
            end

            if (w_byte_vld) begin
                case (r_state)
                    ST_HUNT: r_chk <= 8'h00;
                    ST_ADDR: begin
                        r_addr_buf <= rxf_rddata_i;
                        r_chk      <= r_chk ^ rxf_rddata_i;
                    end
                    ST_D3, ST_D2, ST_D1, ST_D0: begin
                        r_data_buf <= {r_data_buf[23:0], rxf_rddata_i};
                        r_chk      <= r_chk ^ rxf_rddata_i;
                    end
                    ST_CHK: begin
                        if (w_chk_ok) begin
                            r_reg_wr    <= 1'b1;
                            r_reg_addr  <= r_addr_buf;
                            r_reg_wdata <= r_data_buf;
                            r_resp      <= ACK_BYTE;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_nak) begin
                r_resp <= NAK_BYTE;
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end

            if ((r_state == ST_RESP) && !txe_wrfull_i) begin
                r_txe_wrreq  <= 1'b1;
                r_txe_wrdata <= r_resp;
            end
        end
    end

    assign txe_wrreq_o  = r_txe_wrreq;
    assign txe_wrdata_o = r_txe_wrdata;
    assign reg_wr_o     = r_reg_wr;
    assign reg_addr_o   = r_reg_addr;
    assign reg_wdata_o  = r_reg_wdata;
    assign err_cnt_o    = r_err_cnt;

endmodule : usb_cmd_parser
`default_nettype wire

// File: tb/tb_usb_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_cmd_parser
// Description : Directed self-checking bench for usb_cmd_parser with a
//               queue-based RX FIFO model and a TX/register-write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_cmd_parser;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b1;
    logic        rxf_rdreq_o;
    logic [7:0]  rxf_rddata_i  = 8'h00;
    logic [8:0]  rxf_rdusedw_i = 9'd0;
    logic        txe_wrreq_o;
    logic [7:0]  txe_wrdata_o;
    logic        txe_wrfull_i  = 1'b0;
    logic        reg_wr_o;
    logic [7:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [15:0] err_cnt_o;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    int          cyc = 0;
    int          tx_cyc = 0;
    int          last_rd_cyc = 0;
    int          rel_cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          wr_wide = 0;
    logic        wr_prev = 1'b0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] last_wdata = 32'h0;
    int          n_checks = 0;
    int          n_errors = 0;

    usb_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .rxf_rdreq_o   (rxf_rdreq_o),
        .rxf_rddata_i  (rxf_rddata_i),
        .rxf_rdusedw_i (rxf_rdusedw_i),
        .txe_wrreq_o   (txe_wrreq_o),
        .txe_wrdata_o  (txe_wrdata_o),
        .txe_wrfull_i  (txe_wrfull_i),
        .reg_wr_o      (reg_wr_o),
        .reg_addr_o    (reg_addr_o),
        .reg_wdata_o   (reg_wdata_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Non-showahead RX FIFO: data appears the cycle after the request.
    always @(posedge clk_i) begin
        cyc = cyc + 1;
        if (rxf_rdreq_o && (rx_q.size() != 0)) begin
            rxf_rddata_i <= rx_q.pop_front();
        end
    end

    always @(negedge clk_i) begin
        rxf_rdusedw_i = 9'(rx_q.size());
        if (reg_wr_o) begin
            wr_cnt     = wr_cnt + 1;
            last_addr  = reg_addr_o;
            last_wdata = reg_wdata_o;
        end
        if (reg_wr_o && wr_prev) wr_wide = wr_wide + 1;
        wr_prev = reg_wr_o;
        if (txe_wrreq_o) begin
            tx_q.push_back(txe_wrdata_o);
            tx_cyc = cyc;
        end
        if (rxf_rdreq_o) begin
            rd_cnt      = rd_cnt + 1;
            last_rd_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk_i);
        wr_cnt  = 0;
        rd_cnt  = 0;
        wr_wide = 0;
        tx_q.delete();
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] chk);
        @(negedge clk_i);
        rx_q.push_back(8'hA5);
        rx_q.push_back(a);
        rx_q.push_back(d[31:24]);
        rx_q.push_back(d[23:16]);
        rx_q.push_back(d[15:8]);
        rx_q.push_back(d[7:0]);
        rx_q.push_back(chk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while ((tx_q.size() < n) && (k < budget)) begin
            @(posedge clk_i);
            k = k + 1;
        end
        if (tx_q.size() < n) check_val("tx_wait", 32'(tx_q.size()), 32'(n));
        repeat (10) @(posedge clk_i);
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_rdreq"}, 32'(rxf_rdreq_o), 32'd0);
        check_val({pfx, "_wrreq"}, 32'(txe_wrreq_o), 32'd0);
        check_val({pfx, "_wrdata"}, 32'(txe_wrdata_o), 32'd0);
        check_val({pfx, "_regwr"}, 32'(reg_wr_o), 32'd0);
        check_val({pfx, "_addr"}, 32'(reg_addr_o), 32'd0);
        check_val({pfx, "_wdata"}, reg_wdata_o, 32'd0);
        check_val({pfx, "_errcnt"}, 32'(err_cnt_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("rst");
        rst = 1'b0;

        // Good frame; XOR of 10 DE AD BE EF is 8'h32.
        clear_mon();
        push_frame(8'h10, 32'hDEADBEEF, 8'h32);
        wait_tx(1, 200);
        check_val("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        check_val("t1_wr_width", 32'(wr_wide), 32'd0);
        check_val("t1_addr", 32'(last_addr), 32'h10);
        check_val("t1_wdata", last_wdata, 32'hDEADBEEF);
        check_val("t1_tx_cnt", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() != 0) check_val("t1_tx_byte", 32'(tx_q[0]), 32'h06);
        check_val("t1_err", 32'(err_cnt_o), 32'd0);

        // Same frame with a wrong checksum.
        clear_mon();
        push_frame(8'h10, 32'hDEADBEEF, 8'h00);
        wait_tx(1, 200);
        check_val("t2_wr_cnt", 32'(wr_cnt), 32'd0);
        if (tx_q.size() != 0) check_val("t2_tx_byte", 32'(tx_q[0]), 32'h15);
        check_val("t2_err", 32'(err_cnt_o), 32'd1);

        // Garbage then a frame whose ADDR equals the SYNC value.
        // Checksum: A5^01^02^03^04 = A1.
        clear_mon();
        @(negedge clk_i);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        rx_q.push_back(8'hA4);
        push_frame(8'hA5, 32'h01020304, 8'hA1);
        wait_tx(1, 300);
        check_val("t3_wr_cnt", 32'(wr_cnt), 32'd1);
        check_val("t3_addr", 32'(last_addr), 32'hA5);
        check_val("t3_wdata", last_wdata, 32'h01020304);
        check_val("t3_tx_cnt", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() != 0) check_val("t3_tx_byte", 32'(tx_q[0]), 32'h06);
        check_val("t3_err", 32'(err_cnt_o), 32'd1);

        // Partial frame then silence: NAK after the 100-cycle timeout.
        // Last byte_vld is one cycle after the last request; the counter hits
        // 99 100 cycles later, RESP follows, then the registered write: 103.
        clear_mon();
        @(negedge clk_i);
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'hDE);
        wait_tx(1, 300);
        if (tx_q.size() != 0) check_val("t4_tx_byte", 32'(tx_q[0]), 32'h15);
        check_val("t4_delay", 32'(tx_cyc - last_rd_cyc), 32'd103);
        check_val("t4_err", 32'(err_cnt_o), 32'd2);
        clear_mon();
        push_frame(8'h10, 32'hDEADBEEF, 8'h32);
        wait_tx(1, 200);
        check_val("t4_wr_cnt", 32'(wr_cnt), 32'd1);
        if (tx_q.size() != 0) check_val("t4_ack", 32'(tx_q[0]), 32'h06);

        // TX FIFO full while in RESP, with one more byte waiting in RX.
        clear_mon();
        @(negedge clk_i);
        txe_wrfull_i = 1'b1;
        push_frame(8'h10, 32'hDEADBEEF, 8'h32);
        @(negedge clk_i);
        rx_q.push_back(8'h00);
        repeat (30) @(posedge clk_i);
        check_val("t5_wr_cnt", 32'(wr_cnt), 32'd1);
        clear_mon();
        repeat (50) @(posedge clk_i);
        @(negedge clk_i);
        check_val("t5_hold_rd", 32'(rd_cnt), 32'd0);
        check_val("t5_hold_tx", 32'(tx_q.size()), 32'd0);
        txe_wrfull_i = 1'b0;
        rel_cyc      = cyc;
        wait_tx(1, 50);
        check_val("t5_tx_cnt", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() != 0) check_val("t5_tx_byte", 32'(tx_q[0]), 32'h06);
        check_val("t5_delay", 32'(tx_cyc - rel_cyc), 32'd1);

        // Reset after the D2 byte abandons the frame.
        clear_mon();
        @(negedge clk_i);
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'hDE);
        rx_q.push_back(8'hAD);
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        rst = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("t6_rst");
        rst = 1'b0;
        clear_mon();
        repeat (150) @(posedge clk_i);
        check_val("t6_no_resp", 32'(tx_q.size()), 32'd0);
        push_frame(8'h3C, 32'h12345678, 8'h34);
        wait_tx(1, 200);
        check_val("t6_tx_cnt", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() != 0) check_val("t6_tx_byte", 32'(tx_q[0]), 32'h06);
        check_val("t6_wr_cnt", 32'(wr_cnt), 32'd1);
        check_val("t6_addr", 32'(last_addr), 32'h3C);
        check_val("t6_wdata", last_wdata, 32'h12345678);
        check_val("t6_err", 32'(err_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_usb_cmd_parser
`default_nettype wire
